// File: rtl/task_seq_pkg.sv
// Shared definitions for the task microprogram sequencer: opcodes, FSM
// states and instruction-word field offsets.
package task_seq_pkg;

  localparam logic [1:0] OP_NEXT   = 2'd0;
  localparam logic [1:0] OP_JUMP   = 2'd1;
  localparam logic [1:0] OP_REPEAT = 2'd2;
  localparam logic [1:0] OP_HALT   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_EXEC   = 2'd3
  } state_t;

  // Instruction word layout, MSB to LSB: op, rpt, jp, tasks.
  function automatic int unsigned instr_w(input int unsigned pc_w,
                                          input int unsigned tasks_w,
                                          input int unsigned cnt_w);
    return 2 + cnt_w + pc_w + tasks_w;
  endfunction

  function automatic int unsigned jp_lsb(input int unsigned tasks_w);
    return tasks_w;
  endfunction

  function automatic int unsigned rpt_lsb(input int unsigned pc_w,
                                          input int unsigned tasks_w);
    return tasks_w + pc_w;
  endfunction

  function automatic int unsigned op_lsb(input int unsigned pc_w,
                                         input int unsigned tasks_w,
                                         input int unsigned cnt_w);
    return tasks_w + pc_w + cnt_w;
  endfunction

endpackage

// File: rtl/task_seq_ctrl_rpt_cnt.sv
// Loadable repeat down-counter for the sequencer.
// Ports: clk, reset (async, active-high), load/load_val (load has priority),
//        dec (decrement, saturates at 0), zero (count is 0).
module task_rpt_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/task_seq_ctrl.sv
// Microprogram sequencer driving the synthesizer task datapath.
// Fetches words from a 1-cycle-latency synchronous ROM and executes them.
// Ports: clk, reset (async, active-high); start/start_addr/abort from the
//        voice controller; busy/done back to it; rom_rd/rom_addr/rom_data
//        to the microcode ROM; tasks/tasks_vld to the datapath; pc_out debug.
module task_seq_ctrl
  import task_seq_pkg::*;
#(
  parameter  int unsigned PC_W    = 4,
  parameter  int unsigned TASKS_W = 16,
  parameter  int unsigned CNT_W   = 4,
  localparam int unsigned INSTR_W = instr_w(PC_W, TASKS_W, CNT_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    start_addr,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               rom_rd,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [TASKS_W-1:0] tasks,
  output logic               tasks_vld,
  output logic [PC_W-1:0]    pc_out
);

  localparam int unsigned JP_LSB  = jp_lsb(TASKS_W);
  localparam int unsigned RPT_LSB = rpt_lsb(PC_W, TASKS_W);
  localparam int unsigned OP_LSB  = op_lsb(PC_W, TASKS_W, CNT_W);

  state_t             state;
  state_t             state_nxt;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_nxt;
  logic [INSTR_W-1:0] ir;
  logic               ir_load;
  logic               done_nxt;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;

  logic [1:0]         ir_op;
  logic [PC_W-1:0]    ir_jp;
  logic [TASKS_W-1:0] ir_tasks;
  logic               unused_ir_rpt;

  assign ir_op         = ir[OP_LSB +: 2];
  assign ir_jp         = ir[JP_LSB +: PC_W];
  assign ir_tasks      = ir[0 +: TASKS_W];
  // The repeat field is consumed straight from rom_data at load time.
  assign unused_ir_rpt = ^ir[RPT_LSB +: CNT_W];

  task_rpt_cnt #(
    .CNT_W (CNT_W)
  ) u_rpt_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (rom_data[RPT_LSB +: CNT_W]),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers: pc, ir and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc   <= '0;
      ir   <= '0;
      done <= 1'b0;
    end else begin
      pc   <= pc_nxt;
      done <= done_nxt;
      if (ir_load) begin
        ir <= rom_data;
      end
    end
  end

  // Next-state and register-update logic; abort overrides everything and
  // leaves pc/ir untouched.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_load   = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    done_nxt  = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc_nxt    = start_addr;
            state_nxt = ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_nxt = ST_DECODE;
        end
        ST_DECODE: begin
          ir_load   = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = ST_EXEC;
        end
        ST_EXEC: begin
          case (ir_op)
            OP_NEXT: begin
              pc_nxt    = pc + PC_W'(1);
              state_nxt = ST_FETCH;
            end
            OP_JUMP: begin
              pc_nxt    = ir_jp;
              state_nxt = ST_FETCH;
            end
            OP_REPEAT: begin
              if (cnt_zero) begin
                pc_nxt    = pc + PC_W'(1);
                state_nxt = ST_FETCH;
              end else begin
                cnt_dec = 1'b1;
              end
            end
            default: begin
              done_nxt  = 1'b1;
              state_nxt = ST_IDLE;
            end
          endcase
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy      = (state != ST_IDLE);
    rom_rd    = (state == ST_FETCH);
    rom_addr  = pc;
    pc_out    = pc;
    tasks_vld = (state == ST_EXEC);
    tasks     = (state == ST_EXEC) ? ir_tasks : '0;
  end

endmodule

// File: tb/tb_task_seq_ctrl.sv
module tb_task_seq_ctrl;
  import task_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  start_addr;
  logic        abort;
  logic        busy;
  logic        done;
  logic        rom_rd;
  logic [3:0]  rom_addr;
  logic [25:0] rom_data;
  logic [15:0] tasks;
  logic        tasks_vld;
  logic [3:0]  pc_out;

  logic [25:0] rom [16];
  int checks   = 0;
  int failures = 0;

  task_seq_ctrl #(.PC_W(4), .TASKS_W(16), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .abort(abort), .busy(busy), .done(done), .rom_rd(rom_rd),
    .rom_addr(rom_addr), .rom_data(rom_data), .tasks(tasks),
    .tasks_vld(tasks_vld), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model, one cycle latency.
  always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

  function automatic logic [25:0] mk(input logic [1:0] op, input logic [3:0] rpt,
                                     input logic [3:0] jp, input logic [15:0] t);
    return {op, rpt, jp, t};
  endfunction

  // Issue start at edge 0; returns in cycle 1 (sampling at negedge).
  task automatic kick(input logic [3:0] a);
    start = 1'b1; start_addr = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    int rd_seen;
    reset = 1'b1; start = 1'b0; abort = 1'b0; start_addr = 4'h0;
    for (int i = 0; i < 16; i++) rom[i] = mk(OP_HALT, 4'h0, 4'h0, 16'h0);
    rom[2]  = mk(OP_NEXT,   4'h0, 4'h0, 16'h0001);
    rom[3]  = mk(OP_JUMP,   4'h0, 4'h8, 16'h0002);
    rom[8]  = mk(OP_HALT,   4'h0, 4'h0, 16'h0004);
    rom[4]  = mk(OP_REPEAT, 4'h3, 4'h0, 16'h00F0);
    rom[5]  = mk(OP_REPEAT, 4'h0, 4'h0, 16'h0F00);
    rom[6]  = mk(OP_HALT,   4'h0, 4'h0, 16'h0000);
    rom[9]  = mk(OP_REPEAT, 4'h5, 4'h0, 16'h0055);
    rom[10] = mk(OP_HALT,   4'h0, 4'h0, 16'h0000);
    rom[15] = mk(OP_NEXT,   4'h0, 4'h0, 16'h1234);
    rom[0]  = mk(OP_HALT,   4'h0, 4'h0, 16'h0000);
    @(negedge clk); @(negedge clk);
    checks++;
    if ({busy, done, rom_rd, tasks_vld} !== 4'b0000 || rom_addr !== 4'h0 ||
        tasks !== 16'h0 || pc_out !== 4'h0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b done=%b rd=%b vld=%b addr=%h tasks=%h pc=%h required all 0",
               busy, done, rom_rd, tasks_vld, rom_addr, tasks, pc_out);
    end
    reset = 1'b0;
    rd_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rom_rd || busy) rd_seen++;
    end
    checks++;
    if (rd_seen !== 0) begin
      failures++;
      $display("FAIL idle_no_fetch active_cycles=%0d required 0", rd_seen);
    end
  endtask

  task automatic test_program();
    logic e_vld, e_rd, e_done, e_busy;
    logic [15:0] e_tasks;
    logic [3:0]  e_addr;
    int got;
    kick(4'h2);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      e_vld   = (c == 3 || c == 6 || c == 9);
      e_tasks = (c == 3) ? 16'h0001 : (c == 6) ? 16'h0002 : (c == 9) ? 16'h0004 : 16'h0000;
      e_rd    = (c == 1 || c == 4 || c == 7);
      e_addr  = (c <= 3) ? 4'h2 : (c <= 6) ? 4'h3 : 4'h8;
      e_done  = (c == 10);
      e_busy  = (c < 10);
      checks++;
      if (tasks_vld !== e_vld || tasks !== e_tasks) begin
        failures++;
        $display("FAIL prog_tasks c=%0d vld=%b tasks=%h required vld=%b tasks=%h", c, tasks_vld, tasks, e_vld, e_tasks);
      end
      checks++;
      if (rom_rd !== e_rd || rom_addr !== e_addr) begin
        failures++;
        $display("FAIL prog_rom c=%0d rd=%b addr=%h required rd=%b addr=%h", c, rom_rd, rom_addr, e_rd, e_addr);
      end
      checks++;
      if (done !== e_done || busy !== e_busy) begin
        failures++;
        $display("FAIL prog_done c=%0d done=%b busy=%b required done=%b busy=%b", c, done, busy, e_done, e_busy);
      end
    end
    // Start accepted in the same cycle as done.
    kick(4'h8);
    checks++;
    if (rom_rd !== 1'b1 || rom_addr !== 4'h8) begin
      failures++;
      $display("FAIL back_to_back rd=%b addr=%h required rd=1 addr=8", rom_rd, rom_addr);
    end
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      if (done) got = i + 2;
    end
    checks++;
    if (got !== 4) begin
      failures++;
      $display("FAIL back_to_back_done cycle=%0d required 4", got);
    end
  endtask

  task automatic test_repeat();
    logic e_vld, e_rd, e_done;
    logic [15:0] e_tasks;
    logic [3:0]  e_addr;
    kick(4'h4);
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) @(negedge clk);
      e_vld   = (c >= 3 && c <= 6) || c == 9 || c == 12;
      e_tasks = (c >= 3 && c <= 6) ? 16'h00F0 : (c == 9) ? 16'h0F00 : 16'h0000;
      e_rd    = (c == 1 || c == 7 || c == 10);
      e_addr  = (c <= 6) ? 4'h4 : (c <= 9) ? 4'h5 : 4'h6;
      e_done  = (c == 13);
      checks++;
      if (tasks_vld !== e_vld || tasks !== e_tasks) begin
        failures++;
        $display("FAIL rpt_tasks c=%0d vld=%b tasks=%h required vld=%b tasks=%h", c, tasks_vld, tasks, e_vld, e_tasks);
      end
      checks++;
      if (rom_rd !== e_rd || rom_addr !== e_addr || done !== e_done) begin
        failures++;
        $display("FAIL rpt_rom c=%0d rd=%b addr=%h done=%b required rd=%b addr=%h done=%b",
                 c, rom_rd, rom_addr, done, e_rd, e_addr, e_done);
      end
    end
  endtask

  task automatic test_wrap();
    int got;
    kick(4'hF);
    @(negedge clk); @(negedge clk);
    checks++;
    if (tasks !== 16'h1234) begin
      failures++;
      $display("FAIL wrap_exec tasks=%h required 1234", tasks);
    end
    @(negedge clk);
    checks++;
    if (rom_rd !== 1'b1 || rom_addr !== 4'h0 || pc_out !== 4'h0) begin
      failures++;
      $display("FAIL wrap_addr rd=%b addr=%h pc=%h required rd=1 addr=0 pc=0", rom_rd, rom_addr, pc_out);
    end
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    checks++;
    if (got !== 1) begin
      failures++;
      $display("FAIL wrap_done timeout got=%0d required 1", got);
    end
  endtask

  task automatic test_abort();
    int dn;
    kick(4'h9);
    @(negedge clk); @(negedge clk); @(negedge clk);
    checks++;
    if (tasks_vld !== 1'b1 || tasks !== 16'h0055) begin
      failures++;
      $display("FAIL abort_pre vld=%b tasks=%h required vld=1 tasks=0055", tasks_vld, tasks);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || tasks_vld !== 1'b0 || tasks !== 16'h0 || done !== 1'b0 || pc_out !== 4'h9) begin
      failures++;
      $display("FAIL abort_idle busy=%b vld=%b tasks=%h done=%b pc=%h required 0 0 0000 0 9",
               busy, tasks_vld, tasks, done, pc_out);
    end
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    checks++;
    if (dn !== 0) begin
      failures++;
      $display("FAIL abort_no_done active_cycles=%0d required 0", dn);
    end
    start = 1'b1; abort = 1'b1; start_addr = 4'h2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || rom_rd !== 1'b0) begin
      failures++;
      $display("FAIL abort_over_start busy=%b rd=%b required 0 0", busy, rom_rd);
    end
  endtask

  task automatic test_busy_start();
    kick(4'h2);
    for (int c = 2; c <= 11; c++) begin
      @(negedge clk);
      start = (c == 4);
      start_addr = 4'hC;
      if (c == 7) begin
        checks++;
        if (rom_rd !== 1'b1 || rom_addr !== 4'h8) begin
          failures++;
          $display("FAIL busy_start_addr rd=%b addr=%h required rd=1 addr=8", rom_rd, rom_addr);
        end
      end
      if (c == 10) begin
        checks++;
        if (done !== 1'b1) begin
          failures++;
          $display("FAIL busy_start_done done=%b required 1", done);
        end
      end
      if (c == 11) begin
        checks++;
        if (busy !== 1'b0 || rom_rd !== 1'b0) begin
          failures++;
          $display("FAIL busy_start_queued busy=%b rd=%b required 0 0", busy, rom_rd);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    int act, got;
    kick(4'h4);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, rom_rd, tasks_vld} !== 4'b0000 || tasks !== 16'h0 ||
        rom_addr !== 4'h0 || pc_out !== 4'h0) begin
      failures++;
      $display("FAIL reset_mid busy=%b done=%b rd=%b vld=%b tasks=%h addr=%h pc=%h required all 0",
               busy, done, rom_rd, tasks_vld, tasks, rom_addr, pc_out);
    end
    @(negedge clk);
    reset = 1'b0;
    act = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy) act++;
    end
    checks++;
    if (act !== 0) begin
      failures++;
      $display("FAIL reset_mid_quiet active_cycles=%0d required 0", act);
    end
    kick(4'h2);
    checks++;
    if (rom_rd !== 1'b1 || rom_addr !== 4'h2) begin
      failures++;
      $display("FAIL restart_fetch rd=%b addr=%h required rd=1 addr=2", rom_rd, rom_addr);
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if (tasks_vld !== 1'b1 || tasks !== 16'h0001) begin
      failures++;
      $display("FAIL restart_exec vld=%b tasks=%h required vld=1 tasks=0001", tasks_vld, tasks);
    end
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    checks++;
    if (got !== 1) begin
      failures++;
      $display("FAIL restart_done timeout got=%0d required 1", got);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_repeat();
    test_wrap();
    test_abort();
    test_busy_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/task_seq_ctrl.md
# task_seq_ctrl

Microprogram sequencer that drives the synthesizer task datapath. On `start` it fetches microinstructions from an external synchronous ROM and executes them one at a time. Each instruction presents a task bit-vector to the datapath for one or more cycles, then advances, jumps, repeats or halts. The block sits between the voice/channel controller (start/abort/done handshake) and the task datapath plus its microcode ROM.

## Interface
Parameters:
- `PC_W`, 4: program counter / ROM address width.
- `TASKS_W`, 16: width of task bit-vector.
- `CNT_W`, 4: repeat-count field width.
- `INSTR_W` (derived localparam) = 2+CNT_W+PC_W+TASKS_W = 26. Not overridable.

Ports (reset: reset, asynchronous, active-high; clock: clk):
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  start request; honoured only in IDLE.
- `start_addr`  in  PC_W  entry point of the program.
- `abort`  in  1  synchronous abort; returns the block to IDLE from any state.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse after a HALT completes.
- `rom_rd`  out  1  ROM read strobe.
- `rom_addr`  out  PC_W  ROM address.
- `rom_data`  in  INSTR_W  ROM word, valid the cycle after `rom_rd`.
- `tasks`  out  TASKS_W  active task vector; 0 outside EXEC.
- `tasks_vld`  out  1  high in every EXEC cycle.
- `pc_out`  out  PC_W  current PC, for debug.

## Operation
- Instruction word, MSB to LSB: `op[1:0]`, `rpt[CNT_W-1:0]`, `jp[PC_W-1:0]`, `tasks[TASKS_W-1:0]`.
- Op encodings:
  - NEXT = 0
  - JUMP = 1
  - REPEAT = 2
  - HALT = 3
- States and transitions:
  - IDLE: on `start`, pc <= start_addr, go to FETCH.
  - FETCH: `rom_rd`=1, `rom_addr`=pc; go to DECODE.
  - DECODE: latch `rom_data` into ir; cnt <= rpt field; go to EXEC.
  - EXEC: `tasks`=ir.tasks, `tasks_vld`=1, then act on the opcode:
    - NEXT: pc <= pc+1, go to FETCH.
    - JUMP: pc <= ir.jp, go to FETCH.
    - REPEAT: if cnt==0, pc <= pc+1 and go to FETCH; else cnt <= cnt-1 and stay in EXEC. The task vector is held for exactly rpt+1 cycles.
    - HALT: go to IDLE; `done` is registered high for the next cycle only. pc is unchanged.
- Decode combinational outputs from registers only: `rom_rd`, `rom_addr`=pc, `tasks`, `tasks_vld`, `busy`, `pc_out`=pc.
- pc+1 wraps modulo 2^PC_W (0xF -> 0x0). No overflow flag.
- `abort` is sampled every cycle. It forces IDLE on the next edge and `done` is not asserted. pc and ir keep their values.
- `abort` has priority over `start` when both are high in IDLE; the block stays in IDLE.
- `start` while busy is ignored; it is not queued.
- A REPEAT with rpt=0 behaves exactly like NEXT.
- Reset values:
  - State: IDLE.
  - Registers: pc, ir, cnt all 0.
  - Outputs: `done`=0, `busy`=0, `rom_rd`=0, `rom_addr`=0, `tasks`=0, `tasks_vld`=0, `pc_out`=0.
- Reset asserted mid-program: all registers and outputs take their reset values immediately (asynchronously). No `done` is generated.

## Timing
- `start` sampled at edge 0:
  - cycle 1: FETCH.
  - cycle 2: DECODE.
  - cycle 3: first EXEC, `tasks_vld`=1.
- Cost per instruction:
  - NEXT/JUMP: 3 cycles.
  - REPEAT: 2+rpt+1 cycles.
  - HALT: 3 cycles, then `done` in the cycle after its EXEC (the cycle `busy` drops).
- `start` may be accepted on the same edge at which `done` is high.
- ROM latency is exactly 1 cycle. The ROM must hold `rom_data` stable only during DECODE.

## Structure
- Package `task_seq_pkg`:
  - Op encodings `OP_NEXT`, `OP_JUMP`, `OP_REPEAT`, `OP_HALT`.
  - State enum.
  - Field-offset functions parameterised by `PC_W`, `TASKS_W`, `CNT_W`.
- One sub-module, `task_rpt_cnt`: loadable down-counter with load/dec inputs and a zero flag.
- FSM, pc and ir live in the top module.

## Test plan
- Reset with the ROM preloaded -> all outputs 0 and `busy`=0. `start` is held low for 10 cycles -> no `rom_rd`.
- Program at 0x2: NEXT tasks=0x0001; JUMP jp=0x8 tasks=0x0002; at 0x8 HALT tasks=0x0004. `start`, start_addr=2 -> `tasks_vld` pulses at cycles 3, 6 and 9 with 0x0001, 0x0002, 0x0004. `rom_addr` sequence is 2, 3, 8. `done` at cycle 10.
- REPEAT rpt=3 tasks=0x00F0 -> `tasks`=0x00F0 for exactly 4 consecutive cycles, then FETCH of pc+1. REPEAT rpt=0 -> a single cycle.
- NEXT at pc=0xF -> next `rom_addr`=0x0.
- `abort` during the 2nd cycle of a REPEAT rpt=5 -> IDLE on the next edge, `tasks_vld`=0, no `done`. `start` together with `abort` in IDLE -> no FETCH.
- `start` pulsed while busy -> ignored. Reset asserted during EXEC -> outputs 0 asynchronously. A later `start` runs the program from start_addr.
